ysyx_22050598_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the ysyx_22050598 core. Drives the instruction-memory
//  and data-memory handshakes, strobes the IR/PC/regfile write enables, and walks

---
 rtl/ysyx_22050598_ctrl_fsm.sv | 163 ++++++++++++++++
 tb/tb_ysyx_22050598_ctrl_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_ctrl_fsm.sv
// Multi-cycle sequencer: FETCH->DECODE->EXEC->MEM->WB with ebreak/illegal/bus-timeout halt.
// Optional performance counters are enabled by defining YSYX_22050598_PERF_CNT_EN.
module ysyx_22050598_ctrl_fsm #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [11:0] i_imm12,
    input  logic [4:0]  i_rd,
    input  logic [5:0]  i_dtype,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_we,
    output logic        o_rf_we,
    output logic        o_pc_we,
    output logic        o_halt,
    output logic [1:0]  o_cause,
    output logic [2:0]  o_state
`ifdef YSYX_22050598_PERF_CNT_EN
    ,
    output logic [63:0] o_perf_cycle,
    output logic [63:0] o_perf_instret
`endif
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // Last waiting cycle on which an ack is still accepted.
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_MAX - 1);

    state_e           r_state;
    logic [1:0]       r_cause;
    logic [TMO_W-1:0] r_tmo;

    logic w_system;
    logic w_ebreak;
    logic w_mem_op;
    logic w_wr_type;

    assign w_system  = (i_opcode == OpSystem);
    assign w_ebreak  = w_system && (i_funct3 == 3'd0) && (i_imm12 == 12'd1);
    assign w_mem_op  = (i_opcode == OpLoad) || (i_opcode == OpStore);
    assign w_wr_type = i_dtype[5] | i_dtype[2] | i_dtype[1] | i_dtype[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cause <= 2'b00;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_run) begin
                        r_state <= StFetch;
                        r_tmo   <= '0;
                    end
                end
                StFetch: begin
                    if (i_imem_ack) begin
                        r_state <= StDecode;
                    end else if (r_tmo == TmoLast) begin
                        r_state <= StHalt;
                        r_cause <= 2'b11;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StDecode: begin
                    if (i_dtype == 6'd0) begin
                        r_state <= StHalt;
                        r_cause <= 2'b10;
                    end else begin
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (w_ebreak) begin
                        r_state <= StHalt;
                        r_cause <= 2'b01;
                    end else if (w_mem_op) begin
                        r_state <= StMem;
                        r_tmo   <= '0;
                    end else begin
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (i_dmem_ack) begin
                        r_state <= StWb;
                    end else if (r_tmo == TmoLast) begin
                        r_state <= StHalt;
                        r_cause <= 2'b11;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StWb: begin
                    if (i_run) begin
                        r_state <= StFetch;
                        r_tmo   <= '0;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StHalt: r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Strobes are decoded from state; only ir_we also depends on the fetch ack.
    assign o_imem_req = (r_state == StFetch);
    assign o_ir_we    = (r_state == StFetch) && i_imem_ack;
    assign o_dmem_req = (r_state == StMem);
    assign o_dmem_we  = (r_state == StMem) && (i_opcode == OpStore);
    assign o_pc_we    = (r_state == StWb);
    assign o_rf_we    = (r_state == StWb) && w_wr_type && !w_system && (i_rd != 5'd0);
    assign o_halt     = (r_state == StHalt);
    assign o_cause    = r_cause;
    assign o_state    = r_state;

`ifdef YSYX_22050598_PERF_CNT_EN
    logic [63:0] r_perf_cycle;
    logic [63:0] r_perf_instret;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_cycle   <= 64'd0;
            r_perf_instret <= 64'd0;
        end else begin
            if (r_state != StIdle && r_state != StHalt) begin
                r_perf_cycle <= r_perf_cycle + 64'd1;
            end
            if (r_state == StWb) begin
                r_perf_instret <= r_perf_instret + 64'd1;
            end
        end
    end

    assign o_perf_cycle   = r_perf_cycle;
    assign o_perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_ysyx_22050598_ctrl_fsm.sv
// Directed self-checking bench for ysyx_22050598_ctrl_fsm.
// Also checks the performance counters when YSYX_22050598_PERF_CNT_EN is defined.
module tb_ysyx_22050598_ctrl_fsm;

    localparam int TMO_MAX = 255;

    logic        clk;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic [4:0]  rd;
    logic [5:0]  dtype;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        rf_we;
    logic        pc_we;
    logic        halt;
    logic [1:0]  cause;
    logic [2:0]  state;
    logic [6:0]  sb;
`ifdef YSYX_22050598_PERF_CNT_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    int total = 0;
    int bad   = 0;

    ysyx_22050598_ctrl_fsm #(
        .TMO_W  (8),
        .TMO_MAX(TMO_MAX)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_run     (run),
        .i_opcode  (opcode),
        .i_funct3  (funct3),
        .i_imm12   (imm12),
        .i_rd      (rd),
        .i_dtype   (dtype),
        .i_imem_ack(imem_ack),
        .i_dmem_ack(dmem_ack),
        .o_imem_req(imem_req),
        .o_dmem_req(dmem_req),
        .o_dmem_we (dmem_we),
        .o_ir_we   (ir_we),
        .o_rf_we   (rf_we),
        .o_pc_we   (pc_we),
        .o_halt    (halt),
        .o_cause   (cause),
        .o_state   (state)
`ifdef YSYX_22050598_PERF_CNT_EN
        ,
        .o_perf_cycle  (perf_cycle),
        .o_perf_instret(perf_instret)
`endif
    );

    // {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, halt}
    assign sb = {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input bit r, input bit ia, input bit da);
        @(posedge clk);
        #1;
        run      = r;
        imem_ack = ia;
        dmem_ack = da;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm,
                             input logic [4:0] rdi, input logic [5:0] dt);
        opcode = op; funct3 = f3; imm12 = imm; rd = rdi; dtype = dt;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++;
        if (sb !== 7'd0) begin bad++; $display("FAIL reset_strobes: got %b want 0000000", sb); end
        total++;
        if (cause !== 2'd0) begin bad++; $display("FAIL reset_cause: got %0d want 0", cause); end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL idle_hold: got %0d want 0", state); end
    endtask

    // Rows: {run, dmem_ack, state[2:0], strobes[6:0]}
    task automatic test_back_to_back();
        logic [11:0] v [7];
        v = '{12'b1_0_000_0000000, 12'b1_0_001_1001000, 12'b1_0_010_0000000,
              12'b1_0_011_0000000, 12'b1_0_101_0000110, 12'b1_0_001_1001000,
              12'b1_0_010_0000000};
        do_reset();
        set_instr(7'b0010011, 3'd0, 12'd5, 5'd1, 6'b100000);
        for (int i = 0; i < 7; i++) begin
            step(v[i][11], 1'b1, v[i][10]);
            total++;
            if (state !== v[i][9:7])
                begin bad++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, v[i][9:7]); end
            total++;
            if (sb !== v[i][6:0])
                begin bad++; $display("FAIL b2b_strobes[%0d]: got %b want %b", i, sb, v[i][6:0]); end
        end
    endtask

    task automatic test_load();
        logic [11:0] v [10];
        v = '{12'b1_0_000_0000000, 12'b1_0_001_1001000, 12'b1_0_010_0000000,
              12'b1_0_011_0000000, 12'b1_0_100_0100000, 12'b1_0_100_0100000,
              12'b1_0_100_0100000, 12'b1_1_100_0100000, 12'b0_0_101_0000110,
              12'b0_0_000_0000000};
        do_reset();
        set_instr(7'b0000011, 3'd2, 12'd0, 5'd5, 6'b100000);
        for (int i = 0; i < 10; i++) begin
            step(v[i][11], 1'b1, v[i][10]);
            total++;
            if (state !== v[i][9:7])
                begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, v[i][9:7]); end
            total++;
            if (sb !== v[i][6:0])
                begin bad++; $display("FAIL lw_strobes[%0d]: got %b want %b", i, sb, v[i][6:0]); end
        end
    endtask

    task automatic test_store();
        logic [11:0] v [7];
        v = '{12'b1_0_000_0000000, 12'b1_0_001_1001000, 12'b1_0_010_0000000,
              12'b1_0_011_0000000, 12'b1_1_100_0110000, 12'b0_0_101_0000010,
              12'b0_0_000_0000000};
        do_reset();
        set_instr(7'b0100011, 3'd2, 12'd0, 5'd5, 6'b010000);
        for (int i = 0; i < 7; i++) begin
            step(v[i][11], 1'b1, v[i][10]);
            total++;
            if (state !== v[i][9:7])
                begin bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, v[i][9:7]); end
            total++;
            if (sb !== v[i][6:0])
                begin bad++; $display("FAIL sw_strobes[%0d]: got %b want %b", i, sb, v[i][6:0]); end
        end
    endtask

    task automatic test_wb_write(input string nm, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [11:0] imm, input logic [4:0] rdi,
                                 input logic [5:0] dt, input bit exp_rf);
        do_reset();
        set_instr(op, f3, imm, rdi, dt);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (state !== 3'd5)
            begin bad++; $display("FAIL %s_wb_state: got %0d want 5", nm, state); end
        total++;
        if (sb !== {4'b0000, exp_rf, 1'b1, 1'b0})
            begin bad++; $display("FAIL %s_wb_strobes: got %b want %b", nm, sb,
                                  {4'b0000, exp_rf, 1'b1, 1'b0}); end
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (state !== 3'd0)
            begin bad++; $display("FAIL %s_idle: got %0d want 0", nm, state); end
    endtask

    task automatic test_ebreak();
        logic [11:0] v [6];
        v = '{12'b1_0_000_0000000, 12'b1_0_001_1001000, 12'b1_0_010_0000000,
              12'b1_0_011_0000000, 12'b1_0_110_0000001, 12'b1_0_110_0000001};
        do_reset();
        set_instr(7'b1110011, 3'd0, 12'd1, 5'd0, 6'b100000);
        for (int i = 0; i < 6; i++) begin
            step(v[i][11], 1'b1, v[i][10]);
            total++;
            if (state !== v[i][9:7])
                begin bad++; $display("FAIL ebreak_state[%0d]: got %0d want %0d", i, state, v[i][9:7]); end
            total++;
            if (sb !== v[i][6:0])
                begin bad++; $display("FAIL ebreak_strobes[%0d]: got %b want %b", i, sb, v[i][6:0]); end
        end
        total++;
        if (cause !== 2'd1) begin bad++; $display("FAIL ebreak_cause: got %0d want 1", cause); end
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        total++;
        if (state !== 3'd0 || cause !== 2'd0 || halt !== 1'b0)
            begin bad++; $display("FAIL ebreak_rst: got state=%0d cause=%0d halt=%b want 0/0/0",
                                  state, cause, halt); end
    endtask

    task automatic test_illegal();
        logic [11:0] v [6];
        v = '{12'b1_0_000_0000000, 12'b1_0_001_1001000, 12'b1_0_010_0000000,
              12'b1_0_110_0000001, 12'b1_0_110_0000001, 12'b1_0_110_0000001};
        do_reset();
        set_instr(7'b0010011, 3'd0, 12'd1, 5'd1, 6'b000000);
        for (int i = 0; i < 6; i++) begin
            step(v[i][11], 1'b1, v[i][10]);
            total++;
            if (state !== v[i][9:7])
                begin bad++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, state, v[i][9:7]); end
            total++;
            if (sb !== v[i][6:0])
                begin bad++; $display("FAIL illegal_strobes[%0d]: got %b want %b", i, sb, v[i][6:0]); end
            // An ebreak appearing on the bus while halted must not overwrite the first cause.
            if (i == 3) set_instr(7'b1110011, 3'd0, 12'd1, 5'd0, 6'b100000);
        end
        total++;
        if (cause !== 2'd2) begin bad++; $display("FAIL illegal_cause: got %0d want 2", cause); end
    endtask

    task automatic test_timeout(input string nm, input bit mem, input bit ack_last);
        do_reset();
        if (mem) set_instr(7'b0000011, 3'd2, 12'd0, 5'd5, 6'b100000);
        else     set_instr(7'b0010011, 3'd0, 12'd5, 5'd1, 6'b100000);
        step(1'b1, 1'b0, 1'b0);
        if (!mem) begin
            for (int k = 1; k <= TMO_MAX; k++) begin
                step(1'b1, ack_last && k == TMO_MAX, 1'b0);
                if (k == 1 || k == TMO_MAX) begin
                    total++;
                    if (state !== 3'd1 || imem_req !== 1'b1 || ir_we !== (ack_last && k == TMO_MAX))
                        begin bad++; $display("FAIL %s_fetch[%0d]: got state=%0d req=%b ir_we=%b",
                                              nm, k, state, imem_req, ir_we); end
                end
            end
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (state !== (ack_last ? 3'd2 : 3'd6))
                begin bad++; $display("FAIL %s_next: got %0d want %0d", nm, state,
                                      ack_last ? 2 : 6); end
            total++;
            if (cause !== (ack_last ? 2'd0 : 2'd3) || imem_req !== 1'b0)
                begin bad++; $display("FAIL %s_cause: got cause=%0d req=%b", nm, cause, imem_req); end
        end else begin
            // Fetch waits 4 cycles first so a stale counter would shorten the MEM window.
            for (int k = 1; k <= 5; k++) step(1'b1, k == 5, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            for (int k = 1; k <= TMO_MAX; k++) begin
                step(1'b1, 1'b0, 1'b0);
                if (k == 1 || k == TMO_MAX) begin
                    total++;
                    if (state !== 3'd4 || dmem_req !== 1'b1)
                        begin bad++; $display("FAIL %s_mem[%0d]: got state=%0d req=%b",
                                              nm, k, state, dmem_req); end
                end
            end
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (state !== 3'd6 || cause !== 2'd3 || dmem_req !== 1'b0)
                begin bad++; $display("FAIL %s_halt: got state=%0d cause=%0d req=%b want 6/3/0",
                                      nm, state, cause, dmem_req); end
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        set_instr(7'b0100011, 3'd2, 12'd0, 5'd5, 6'b010000);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (state !== 3'd4 || dmem_req !== 1'b1)
            begin bad++; $display("FAIL midmem_pre: got state=%0d req=%b want 4/1", state, dmem_req); end
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        total++;
        if (state !== 3'd0 || sb !== 7'd0)
            begin bad++; $display("FAIL midmem_rst: got state=%0d strobes=%b want 0/0000000",
                                  state, sb); end
        rst = 1'b0;
    endtask

`ifdef YSYX_22050598_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        set_instr(7'b0010011, 3'd0, 12'd5, 5'd1, 6'b100000);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (perf_instret !== 64'd3)
            begin bad++; $display("FAIL perf_instret: got %0d want 3", perf_instret); end
        total++;
        if (perf_cycle !== 64'd12)
            begin bad++; $display("FAIL perf_cycle: got %0d want 12", perf_cycle); end
    endtask
`endif

    initial begin
        set_instr(7'd0, 3'd0, 12'd0, 5'd0, 6'd0);
        test_reset();
        test_back_to_back();
        test_load();
        test_store();
        test_wb_write("beq",    7'b1100011, 3'd0, 12'd0,  5'd8, 6'b001000, 1'b0);
        test_wb_write("addi0",  7'b0010011, 3'd0, 12'd5,  5'd0, 6'b100000, 1'b0);
        test_wb_write("lui",    7'b0110111, 3'd0, 12'd0,  5'd3, 6'b000100, 1'b1);
        test_wb_write("jal",    7'b1101111, 3'd0, 12'd0,  5'd1, 6'b000010, 1'b1);
        test_wb_write("add",    7'b0110011, 3'd0, 12'd0,  5'd2, 6'b000001, 1'b1);
        test_wb_write("ecall",  7'b1110011, 3'd0, 12'd0,  5'd1, 6'b100000, 1'b0);
        test_ebreak();
        test_illegal();
        test_timeout("tmo_fetch", 1'b0, 1'b0);
        test_timeout("ack_at_max", 1'b0, 1'b1);
        test_timeout("tmo_mem", 1'b1, 1'b0);
        test_reset_mid_mem();
`ifdef YSYX_22050598_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
